control_paralelo_serial: RTL and testbench

CONTROL_PARALELO_SERIAL -- requirements
Module: control_paralelo_serial

---
 rtl/control_paralelo_serial_if.sv | 28 ++
 rtl/control_paralelo_serial.sv | 165 ++++++++++++++++
 tb/tb_control_paralelo_serial.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/control_paralelo_serial_if.sv
// Parallel-word input handshake and serialized byte output bundle for
// control_paralelo_serial.
interface control_paralelo_serial_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_k;
  logic        out_strobe;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_byte,
    input  out_k,
    input  out_strobe
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_byte,
    output out_k,
    output out_strobe
  );
endinterface

// File: rtl/control_paralelo_serial.sv
// Parallel-to-serial byte sequencer: sends a COM sync burst after reset, then
// streams 32-bit words MSB byte first at a programmable tick rate, filling gaps with IDLE.
module control_paralelo_serial #(
  parameter int unsigned SYNC_LEN = 4,
  parameter logic [7:0]  COM_SYM  = 8'hBC,
  parameter logic [7:0]  IDLE_SYM = 8'h7C
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enb,
  input  logic [1:0]                  rate,
  control_paralelo_serial_if.slave    bus,
  output logic                        busy
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_LEN - 1);

  function automatic logic [4:0] rate_period(input logic [1:0] r);
    case (r)
      2'b00:   rate_period = 5'd5;
      2'b01:   rate_period = 5'd10;
      2'b10:   rate_period = 5'd20;
      default: rate_period = 5'd10;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  div_q, div_d;
  logic [4:0]  period_q, period_d;
  logic [3:0]  sync_q, sync_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [31:0] shift_q, shift_d;
  logic [1:0]  rem_q, rem_d;
  logic [7:0]  byte_q, byte_d;
  logic        k_q, k_d;
  logic        strobe_q, strobe_d;

  logic [4:0]  eff_period_s;
  logic        tick_s;
  logic        ready_s;

  // The rate is sampled only when a period starts, so a change mid-period
  // lets the running period finish at its old length.
  assign eff_period_s = (div_q == 5'd0) ? rate_period(rate) : period_q;
  assign tick_s       = (div_q == (eff_period_s - 5'd1));
  assign ready_s      = (state_q != ST_SYNC) && !hold_full_q;

  assign bus.in_ready   = ready_s;
  assign bus.out_byte   = byte_q;
  assign bus.out_k      = k_q;
  assign bus.out_strobe = strobe_q;
  assign busy           = !((state_q == ST_IDLE) && !hold_full_q);

  // Next-state logic for divider, FSM, holding/shift registers and outputs.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    period_d    = period_q;
    sync_d      = sync_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    byte_d      = byte_q;
    k_d         = k_q;
    strobe_d    = 1'b0;

    if (enb) begin
      period_d = eff_period_s;
      strobe_d = tick_s;
      if (tick_s) begin
        div_d = 5'd0;
      end else begin
        div_d = div_q + 5'd1;
      end

      if (bus.in_valid && ready_s) begin
        hold_d      = bus.in_data;
        hold_full_d = 1'b1;
      end else begin
        hold_full_d = hold_full_q;
      end

      if (tick_s) begin
        case (state_q)
          ST_SYNC: begin
            byte_d = COM_SYM;
            k_d    = 1'b1;
            if (sync_q == SYNC_LAST) begin
              state_d = ST_IDLE;
            end else begin
              sync_d = sync_q + 4'd1;
            end
          end
          ST_IDLE, ST_SEND: begin
            if ((state_q == ST_SEND) && (rem_q != 2'd0)) begin
              byte_d  = shift_q[31:24];
              k_d     = 1'b0;
              shift_d = {shift_q[23:0], 8'h00};
              rem_d   = rem_q - 2'd1;
            end else if (hold_full_q) begin
              // Back-to-back words: the next word's first byte follows without an idle gap.
              byte_d      = hold_q[31:24];
              k_d         = 1'b0;
              shift_d     = {hold_q[23:0], 8'h00};
              rem_d       = 2'd3;
              hold_d      = 32'h0000_0000;
              hold_full_d = 1'b0;
              state_d     = ST_SEND;
            end else begin
              byte_d  = IDLE_SYM;
              k_d     = 1'b1;
              shift_d = 32'h0000_0000;
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_SYNC;
          end
        endcase
      end else begin
        state_d = state_q;
      end
    end else begin
      strobe_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      div_q       <= 5'd0;
      period_q    <= 5'd5;
      sync_q      <= 4'd0;
      hold_q      <= 32'h0000_0000;
      hold_full_q <= 1'b0;
      shift_q     <= 32'h0000_0000;
      rem_q       <= 2'd0;
      byte_q      <= 8'h00;
      k_q         <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      period_q    <= period_d;
      sync_q      <= sync_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      byte_q      <= byte_d;
      k_q         <= k_d;
      strobe_q    <= strobe_d;
    end
  end

endmodule

// File: tb/tb_control_paralelo_serial.sv
// Directed bench for control_paralelo_serial: a scoreboard queue holds the
// expected {k,byte} of every strobe; an empty queue means idle fill is expected.
module tb_control_paralelo_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic [1:0] rate;
  logic       busy;

  control_paralelo_serial_if bus ();

  control_paralelo_serial #(
    .SYNC_LEN(4),
    .COM_SYM (8'hBC),
    .IDLE_SYM(8'h7C)
  ) dut (
    .clk (clk),
    .rst (rst),
    .enb (enb),
    .rate(rate),
    .bus (bus.slave),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [8:0] exp_q[$];
  int         stb_cyc[$];
  logic [8:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every strobe pops one expected symbol
  always @(negedge clk) begin
    if (!rst && bus.out_strobe) begin
      if (exp_q.size() > 0) mon_e = exp_q.pop_front();
      else                  mon_e = {1'b1, 8'h7C};
      chk("strobe_sym", {23'd0, bus.out_k, bus.out_byte}, {23'd0, mon_e});
      stb_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_to(input int target, input string tag);
    int k = 0;
    while (stb_cyc.size() < target && k < 400) begin
      step();
      k++;
    end
    chk(tag, stb_cyc.size(), target);
  endtask

  task automatic wait_n(input int n, input string tag);
    wait_to(stb_cyc.size() + n, tag);
  endtask

  function automatic int last_gap();
    if (stb_cyc.size() < 2) return -1;
    return stb_cyc[stb_cyc.size()-1] - stb_cyc[stb_cyc.size()-2];
  endfunction

  task automatic push_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, t[i*8 +: 8]});
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!bus.in_ready && k < 200) begin
      step();
      k++;
    end
    chk(tag, bus.in_ready, 1);
  endtask

  initial begin
    int rel;
    int base;
    rst = 1'b1; enb = 1'b0; rate = 2'b00;
    bus.in_valid = 1'b0; bus.in_data = 32'h0;
    #2;
    chk("rst_out_byte", bus.out_byte, 8'h00);
    chk("rst_out_k", bus.out_k, 0);
    chk("rst_strobe", bus.out_strobe, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 1);
    repeat (3) step();

    // Sync burst at rate 00
    repeat (4) exp_q.push_back({1'b1, 8'hBC});
    rst = 1'b0; enb = 1'b1; rel = cyc;
    wait_n(1, "first_strobe");
    chk("first_latency", stb_cyc[0] - rel, 5);
    wait_n(2, "sync_strobes");
    chk("sync_gap", last_gap(), 5);
    chk("ready_in_sync", bus.in_ready, 0);
    wait_n(1, "sync_4th");
    step();
    chk("ready_after_sync", bus.in_ready, 1);
    chk("busy_idle", busy, 0);
    wait_n(1, "first_idle");
    chk("idle_gap", last_gap(), 5);

    // Single word with an enable gap after its second byte
    push_word(32'h11223344);
    bus.in_valid = 1'b1; bus.in_data = 32'h11223344;
    step();
    bus.in_valid = 1'b0;
    chk("ready_held_full", bus.in_ready, 0);
    chk("busy_held", busy, 1);
    wait_n(2, "word1_b22");
    enb = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("gap_no_strobe", bus.out_strobe, 0);
    end
    chk("gap_byte_hold", bus.out_byte, 8'h22);
    enb = 1'b1;
    wait_n(1, "word1_b33");
    chk("resume_gap", last_gap(), 12);
    wait_n(1, "word1_b44");
    chk("resume_gap2", last_gap(), 5);
    wait_n(1, "word1_idle");
    chk("busy_after_word", busy, 0);

    // Two words back to back, in_valid held
    base = stb_cyc.size();
    push_word(32'hAABBCCDD);
    push_word(32'h01020304);
    bus.in_valid = 1'b1; bus.in_data = 32'hAABBCCDD;
    step();
    chk("ready_low_A", bus.in_ready, 0);
    bus.in_data = 32'h01020304;
    wait_ready("ready_for_B");
    step();
    bus.in_valid = 1'b0;
    chk("ready_low_B", bus.in_ready, 0);
    wait_to(base + 8, "ab_strobes");
    for (int i = base + 1; i < base + 8; i++)
      chk("ab_spacing", stb_cyc[i] - stb_cyc[i-1], 5);
    wait_n(1, "ab_idle");

    // Asynchronous reset in the middle of a word
    push_word(32'h55667788);
    bus.in_valid = 1'b1; bus.in_data = 32'h55667788;
    step();
    bus.in_valid = 1'b0;
    wait_n(2, "w3_partial");
    #2 rst = 1'b1;
    #1;
    chk("arst_byte", bus.out_byte, 8'h00);
    chk("arst_strobe", bus.out_strobe, 0);
    chk("arst_ready", bus.in_ready, 0);
    chk("arst_busy", busy, 1);
    exp_q.delete();
    repeat (4) exp_q.push_back({1'b1, 8'hBC});
    push_word(32'hCAFE0001);
    bus.in_valid = 1'b1; bus.in_data = 32'hCAFE0001;
    step();
    step();
    base = stb_cyc.size();
    rst = 1'b0;
    wait_ready("ready_after_resync");
    chk("resync_count", stb_cyc.size() - base, 4);
    step();
    bus.in_valid = 1'b0;
    wait_to(base + 9, "resync_word");

    // Rate change mid-period
    step(); step();
    rate = 2'b10;
    wait_n(1, "rate_old");
    chk("rate_old_gap", last_gap(), 5);
    wait_n(2, "rate_new");
    chk("rate_new_gap", last_gap(), 20);
    step(); step();
    rate = 2'b11;
    wait_n(1, "rate_r_old");
    chk("rate_r_old_gap", last_gap(), 20);
    wait_n(1, "rate_r_new");
    chk("rate_reserved_gap", last_gap(), 10);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
